div_operand_sequencer: RTL and testbench

//  Upstream feeder for the repeated-subtraction divider (datapath + controller pair).

---
 rtl/div_seq_pkg.sv | 21 ++
 rtl/div_seq_fifo.sv | 80 ++++++++
 rtl/div_operand_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_div_operand_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_seq_pkg.sv
// -----------------------------------------------------------------------------
// div_seq_pkg
// Shared definitions for the divider operand sequencer:
//   - state_t     : sequencer FSM states
//   - DEF_W       : default operand width (matches the divider Data_in bus)
//   - DEF_TIMEOUT : default number of WAIT cycles before a job is abandoned
// -----------------------------------------------------------------------------
package div_seq_pkg;

  localparam int DEF_W       = 16;
  localparam int DEF_TIMEOUT = 1024;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    LOAD_A = 3'd2,
    LOAD_B = 3'd3,
    WAIT   = 3'd4
  } state_t;

endpackage

// File: rtl/div_seq_fifo.sv
// -----------------------------------------------------------------------------
// div_seq_fifo
// Small synchronous FIFO holding packed (dividend, divisor) pairs.
// A write and a read in the same cycle are accepted even when full, because the
// read frees the slot the write is about to use.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   synchronous reset, active-low (flushes pointers and count)
//   wr_en_i    in   write request
//   wr_data_i  in   write data, DW bits
//   rd_en_i    in   read (pop) request; ignored when empty
//   rd_data_o  out  head-of-queue data (valid when not empty)
//   full_o     out  FIFO holds DEPTH entries
//   empty_o    out  FIFO holds no entries
//   count_o    out  number of stored entries
// -----------------------------------------------------------------------------
module div_seq_fifo #(
  parameter  int DEPTH = 2,
  parameter  int DW    = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNTW  = AW + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en_i,
  input  logic [DW-1:0]   wr_data_i,
  input  logic            rd_en_i,
  output logic [DW-1:0]   rd_data_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CNTW-1:0] count_o
);

  logic [DW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CNTW-1:0] count_q;
  logic [CNTW-1:0] count_d;
  logic            do_wr;
  logic            do_rd;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CNTW'(DEPTH));
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  assign do_rd = rd_en_i && !empty_o;
  assign do_wr = wr_en_i && (!full_o || do_rd);

  always_comb begin
    count_d = count_q;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is not reset: entries are only observed once written.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/div_operand_sequencer.sv
// -----------------------------------------------------------------------------
// div_operand_sequencer
// Feeds a repeated-subtraction divider. Buffers (dividend, divisor) pairs and,
// one job at a time, drives the divider's shared Data_in bus and Start pin in
// the order dividend, dividend, divisor, then waits for a rising edge on Stop.
// Divide-by-zero pairs are dropped with a pulse; a stuck job is abandoned
// after TIMEOUT cycles with a pulse; completed jobs are counted.
//
// Handshake: a pair is transferred on every rising clk edge where
//   in_valid && in_ready. in_ready depends only on the FIFO fill level, never
//   on in_valid; upstream must hold the pair stable while in_valid && !in_ready.
//
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   synchronous reset, active-low
//   in_valid     in   operand pair valid
//   in_ready     out  FIFO not full
//   in_dividend  in   dividend, W bits
//   in_divisor   in   divisor, W bits
//   div_data_in  out  to divider Data_in (registered)
//   div_start    out  to divider Start (registered)
//   div_stop     in   from divider Stop (level)
//   busy         out  job in flight or pairs queued
//   err_div0     out  one-cycle pulse: divisor==0 pair dropped
//   err_timeout  out  one-cycle pulse: job abandoned in WAIT
//   jobs_done    out  completed-job counter, wraps
//   dbg_state    out  current FSM state
// -----------------------------------------------------------------------------
module div_operand_sequencer
  import div_seq_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_dividend,
  input  logic [W-1:0]  in_divisor,
  output logic [W-1:0]  div_data_in,
  output logic          div_start,
  input  logic          div_stop,
  output logic          busy,
  output logic          err_div0,
  output logic          err_timeout,
  output logic [CW-1:0] jobs_done,
  output state_t        dbg_state
);

  localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int CNTW = $clog2(DEPTH) + 1;

  // ---------------------------------------------------------------------------
  // Operand FIFO, packed as {dividend, divisor}
  // ---------------------------------------------------------------------------
  logic            fifo_wr;
  logic            fifo_rd;
  logic [2*W-1:0]  fifo_head;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CNTW-1:0] fifo_count;
  logic [W-1:0]    head_dividend;
  logic [W-1:0]    head_divisor;

  div_seq_fifo #(
    .DEPTH (DEPTH),
    .DW    (2*W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (fifo_wr),
    .wr_data_i ({in_dividend, in_divisor}),
    .rd_en_i   (fifo_rd),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  state_t        state_q;
  logic [W-1:0]  dividend_q;
  logic [W-1:0]  divisor_q;
  logic [W-1:0]  data_q;
  logic          start_q;
  logic          err_div0_q;
  logic          err_timeout_q;
  logic [TW-1:0] timer_q;
  logic          stop_q;
  logic [CW-1:0] jobs_q;
  logic          stop_rise;

  assign in_ready = !fifo_full;
  assign fifo_wr  = in_valid && in_ready;
  // The head is consumed whenever the FSM is idle, including div-by-zero drops.
  assign fifo_rd  = (state_q == IDLE) && !fifo_empty;

  assign head_dividend = fifo_head[2*W-1:W];
  assign head_divisor  = fifo_head[W-1:0];

  // stop_q tracks div_stop every cycle, so a level left high by the previous
  // job is already in stop_q when WAIT is entered and does not count as a rise.
  assign stop_rise = div_stop && !stop_q;

  // ---------------------------------------------------------------------------
  // Sequencer FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      dividend_q    <= '0;
      divisor_q     <= '0;
      data_q        <= '0;
      start_q       <= 1'b0;
      err_div0_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      timer_q       <= '0;
      stop_q        <= 1'b0;
      jobs_q        <= '0;
    end else begin
      stop_q        <= div_stop;
      start_q       <= 1'b0;
      err_div0_q    <= 1'b0;
      err_timeout_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            if (head_divisor == '0) begin
              err_div0_q <= 1'b1;
            end else begin
              dividend_q <= head_dividend;
              divisor_q  <= head_divisor;
              state_q    <= START;
            end
          end
        end

        START: begin
          start_q <= 1'b1;
          data_q  <= dividend_q;
          state_q <= LOAD_A;
        end

        LOAD_A: begin
          data_q  <= dividend_q;
          state_q <= LOAD_B;
        end

        LOAD_B: begin
          data_q  <= divisor_q;
          timer_q <= '0;
          state_q <= WAIT;
        end

        WAIT: begin
          data_q <= '0;
          // Completion takes priority over an expiring timer.
          if (stop_rise) begin
            jobs_q  <= jobs_q + CW'(1);
            state_q <= IDLE;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            err_timeout_q <= 1'b1;
            state_q       <= IDLE;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign div_data_in = data_q;
  assign div_start   = start_q;
  assign err_div0    = err_div0_q;
  assign err_timeout = err_timeout_q;
  assign jobs_done   = jobs_q;
  assign busy        = (state_q != IDLE) || (fifo_count != '0);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_div_operand_sequencer.sv
// -----------------------------------------------------------------------------
// tb_div_operand_sequencer
// Directed bench for div_operand_sequencer. A job-level reference model tracks
// the queued pairs and the age of the job in flight, and every cycle the DUT
// outputs are compared against it. Directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_div_operand_sequencer;
  import div_seq_pkg::*;

  localparam int W       = 16;
  localparam int DEPTH   = 2;
  localparam int TIMEOUT = 1024;
  localparam int CW      = 16;
  localparam int STUB_DELAY = 20;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_dividend;
  logic [W-1:0]  in_divisor;
  logic [W-1:0]  div_data_in;
  logic          div_start;
  logic          div_stop;
  logic          busy;
  logic          err_div0;
  logic          err_timeout;
  logic [CW-1:0] jobs_done;
  state_t        dbg_state;

  logic stub_en;
  logic stub_stop;
  logic stop_manual;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign div_stop = stub_en ? stub_stop : stop_manual;

  div_operand_sequencer #(
    .W       (W),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_dividend (in_dividend),
    .in_divisor  (in_divisor),
    .div_data_in (div_data_in),
    .div_start   (div_start),
    .div_stop    (div_stop),
    .busy        (busy),
    .err_div0    (err_div0),
    .err_timeout (err_timeout),
    .jobs_done   (jobs_done),
    .dbg_state   (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Check bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Divider stub: on Start, drop Stop, then raise it STUB_DELAY cycles later
  // ---------------------------------------------------------------------------
  initial begin
    stub_stop = 1'b0;
    forever begin
      @(negedge clk);
      if (stub_en && div_start) begin
        stub_stop = 1'b0;
        repeat (STUB_DELAY) @(negedge clk);
        stub_stop = 1'b1;
      end
    end
  end

  // Event monitors
  int           div0_cnt  = 0;
  int           start_cnt = 0;
  logic [W-1:0] start_log[$];

  always @(negedge clk) begin
    if (err_div0) div0_cnt++;
    if (div_start) begin
      start_cnt++;
      start_log.push_back(div_data_in);
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model: queue of pending pairs plus age of the job in flight.
  // Age counts clock edges since the pair was taken from the queue:
  //   age 1 Start+dividend, age 2 dividend, age 3 divisor, age>=4 waiting.
  // A waiting job ends on a Stop 0->1 seen at an edge, or at age 3+TIMEOUT.
  // ---------------------------------------------------------------------------
  logic [W-1:0]  mq_dvd[$];
  logic [W-1:0]  mq_dvs[$];
  int            m_age = -1;
  logic [W-1:0]  m_cur_dvd;
  logic [W-1:0]  m_cur_dvs;
  logic          m_prev_stop;
  logic          m_acc;
  logic [W-1:0]  m_pd;
  logic [W-1:0]  m_ps;
  logic [W-1:0]  e_data;
  logic          e_start;
  logic          e_div0;
  logic          e_to;
  logic [CW-1:0] e_jobs;

  always @(posedge clk) begin
    e_div0 = 1'b0;
    e_to   = 1'b0;
    if (!rst_n) begin
      mq_dvd.delete();
      mq_dvs.delete();
      m_age       = -1;
      m_prev_stop = 1'b0;
      e_data      = '0;
      e_start     = 1'b0;
      e_jobs      = '0;
    end else begin
      m_acc = in_valid && (mq_dvd.size() < DEPTH);
      if (m_age < 0) begin
        if (mq_dvd.size() > 0) begin
          m_pd = mq_dvd.pop_front();
          m_ps = mq_dvs.pop_front();
          if (m_ps == '0) e_div0 = 1'b1;
          else begin
            m_cur_dvd = m_pd;
            m_cur_dvs = m_ps;
            m_age     = 0;
          end
        end
      end else begin
        m_age++;
        if (m_age == 1 || m_age == 2) e_data = m_cur_dvd;
        else if (m_age == 3) e_data = m_cur_dvs;
        else begin
          e_data = '0;
          if (div_stop && !m_prev_stop) begin
            e_jobs = e_jobs + 1'b1;
            m_age  = -1;
          end else if (m_age == 3 + TIMEOUT) begin
            e_to  = 1'b1;
            m_age = -1;
          end
        end
      end
      e_start = (m_age == 1);
      if (m_acc) begin
        mq_dvd.push_back(in_dividend);
        mq_dvs.push_back(in_divisor);
      end
      m_prev_stop = div_stop;
    end
  end

  // Compare process: every cycle, just after the active edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      check("m_data",     32'(div_data_in), 32'(e_data));
      check("m_start",    32'(div_start),   32'(e_start));
      check("m_div0",     32'(err_div0),    32'(e_div0));
      check("m_timeout",  32'(err_timeout), 32'(e_to));
      check("m_jobs",     32'(jobs_done),   32'(e_jobs));
      check("m_in_ready", 32'(in_ready),    32'(mq_dvd.size() < DEPTH));
      check("m_busy",     32'(busy),        32'((m_age >= 0) || (mq_dvd.size() > 0)));
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called and returning on a falling edge)
  // ---------------------------------------------------------------------------
  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    in_valid    = 1'b1;
    in_dividend = a;
    in_divisor  = b;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("push_accept_bound", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_start(input string name);
    int n;
    n = 0;
    while (!div_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(div_start), 32'd1);
  endtask

  task automatic wait_jobs(input int target, input string name);
    int n;
    n = 0;
    while (jobs_done !== CW'(target) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(jobs_done), 32'(target));
  endtask

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    int d0;
    int s0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_dividend = '0;
    in_divisor  = '0;
    stub_en     = 1'b0;
    stop_manual = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy",  32'(busy),        32'd0);
    check("rst_ready", 32'(in_ready),    32'd1);
    check("rst_jobs",  32'(jobs_done),   32'd0);
    check("rst_start", 32'(div_start),   32'd0);
    check("rst_data",  32'(div_data_in), 32'd0);
    check("rst_state", 32'(dbg_state),   32'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single job, load order and completion
    stub_en = 1'b1;
    push(16'd100, 16'd7);
    @(negedge clk); check("t1_start_pre", 32'(div_start), 32'd0);
    @(negedge clk); check("t1_start", 32'(div_start), 32'd1);
    check("t1_d0", 32'(div_data_in), 32'd100);
    @(negedge clk); check("t1_start_off", 32'(div_start), 32'd0);
    check("t1_d1", 32'(div_data_in), 32'd100);
    @(negedge clk); check("t1_d2", 32'(div_data_in), 32'd7);
    @(negedge clk); check("t1_d3", 32'(div_data_in), 32'd0);
    wait_jobs(1, "t1_jobs");
    @(negedge clk); check("t1_idle", 32'(busy), 32'd0);

    // 2: divide by zero is dropped
    d0 = div0_cnt;
    s0 = start_cnt;
    push(16'd50, 16'd0);
    repeat (6) @(negedge clk);
    check("t2_div0_pulses", 32'(div0_cnt - d0),  32'd1);
    check("t2_no_start",    32'(start_cnt - s0), 32'd0);
    check("t2_jobs",        32'(jobs_done),      32'd1);

    // 3: three back-to-back pairs, FIFO fills, issued in order
    start_log.delete();
    push(16'd200, 16'd3);
    push(16'd300, 16'd4);
    push(16'd400, 16'd5);
    check("t3_ready_low", 32'(in_ready), 32'd0);
    wait_jobs(4, "t3_jobs");
    check("t3_nstarts", 32'(start_log.size()), 32'd3);
    if (start_log.size() == 3) begin
      check("t3_order0", 32'(start_log[0]), 32'd200);
      check("t3_order1", 32'(start_log[1]), 32'd300);
      check("t3_order2", 32'(start_log[2]), 32'd400);
    end

    // 4: no Stop -> timeout, then the queued job runs normally
    stop_manual = 1'b0;
    stub_en     = 1'b0;
    push(16'd1234, 16'd77);
    push(16'd555, 16'd5);
    wait_start("t4_start");
    repeat (2) @(negedge clk);
    check("t4_load_b", 32'(div_data_in), 32'd77);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!err_timeout && n < TIMEOUT + 50);
    check("t4_to_latency", 32'(n), 32'(TIMEOUT));
    check("t4_jobs_after_to", 32'(jobs_done), 32'd4);
    stub_en = 1'b1;
    wait_jobs(5, "t4_next_job");

    // 5: Stop still high from the previous job must not complete the new one
    stop_manual = 1'b1;
    stub_en     = 1'b0;
    push(16'd60, 16'd6);
    wait_start("t5_start");
    repeat (30) @(negedge clk);
    check("t5_stale_ignored", 32'(jobs_done), 32'd5);
    check("t5_busy", 32'(busy), 32'd1);
    stop_manual = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_fall_only", 32'(jobs_done), 32'd5);
    stop_manual = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_rise_done", 32'(jobs_done), 32'd6);

    // 6: reset during WAIT
    stop_manual = 1'b0;
    push(16'd70, 16'd7);
    wait_start("t6_start");
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_state", 32'(dbg_state),   32'(IDLE));
    check("t6_busy",  32'(busy),        32'd0);
    check("t6_ready", 32'(in_ready),    32'd1);
    check("t6_jobs",  32'(jobs_done),   32'd0);
    check("t6_data",  32'(div_data_in), 32'd0);
    check("t6_start", 32'(div_start),   32'd0);
    check("t6_errs",  32'({err_div0, err_timeout}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    stub_en = 1'b1;
    push(16'd9, 16'd3);
    wait_jobs(1, "t6_after_reset");
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
